// File: rtl/ivalu_wb_arbiter.sv
// ivalu_wb_arbiter: writeback stage shared by the ivalu (source A) and a
// second result source (source B). Each source has its own result FIFO
// because neither source can be back-pressured once an op has issued. The
// FIFO heads are arbitrated round-robin onto the single regfile writeback /
// ROB completion port. A registered stall hint goes upstream early enough
// to cover the ops still in flight.
module ivalu_wb_arbiter #(
  parameter int DEPTH = 4,  // entries per source FIFO, power of 2, >= 4
  parameter int SKID  = 2   // ops in flight past issue; stall margin
) (
  input  logic        core_clock_i,
  input  logic        core_reset_i,
  input  logic        flush_i,
  input  logic [31:0] a_result_i,
  input  logic [4:0]  a_rob_i,
  input  logic [5:0]  a_dest_i,
  input  logic        a_wb_valid_i,
  input  logic        a_valid_i,
  output logic        a_stall_o,
  input  logic [31:0] b_result_i,
  input  logic [4:0]  b_rob_i,
  input  logic [5:0]  b_dest_i,
  input  logic        b_wb_valid_i,
  input  logic        b_valid_i,
  output logic        b_stall_o,
  output logic [31:0] wb_data_o,
  output logic [5:0]  wb_dest_o,
  output logic        wb_valid_o,
  output logic [4:0]  cmp_rob_o,
  output logic        cmp_valid_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit distinguishes full from empty.
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  localparam logic [PW-1:0] SKID_W  = PW'(SKID);

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rob;
    logic [5:0]  dest;
    logic        wb;
  } entry_t;

  // Index 0 is source A, index 1 is source B throughout.
  entry_t        in_entry [2];
  logic [1:0]    in_valid;

  entry_t        mem_q [2][DEPTH];
  logic [PW-1:0] wr_q [2];
  logic [PW-1:0] wr_d [2];
  logic [PW-1:0] rd_q [2];
  logic [PW-1:0] rd_d [2];

  logic [1:0]    empty;
  logic [1:0]    full;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    stall_q;
  logic [1:0]    stall_d;
  logic          rr_q;   // source that wins the next tie (0 = A)
  logic          rr_d;
  logic          gnt;
  logic          any_pop;
  entry_t        head;
  logic          overflow_q;
  logic          overflow_d;

  logic [31:0]   wb_data_q, wb_data_d;
  logic [5:0]    wb_dest_q, wb_dest_d;
  logic [4:0]    cmp_rob_q, cmp_rob_d;
  logic          wb_valid_q, wb_valid_d;
  logic          cmp_valid_q, cmp_valid_d;

  // Pack the incoming results of both sources into FIFO entries.
  always_comb begin
    in_entry[0] = '{result: a_result_i, rob: a_rob_i, dest: a_dest_i, wb: a_wb_valid_i};
    in_entry[1] = '{result: b_result_i, rob: b_rob_i, dest: b_dest_i, wb: b_wb_valid_i};
    in_valid    = {b_valid_i, a_valid_i};
  end

  // FIFO status from the pointers as they stand before the edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_q[i] == rd_q[i]);
      full[i]  = (wr_q[i][AW] != rd_q[i][AW]) &&
                 (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
    end
  end

  // Round-robin grant among non-empty FIFOs; a flush suppresses any pop.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    pop = '0;
    gnt = rr_q;
    if (!flush_i) begin
      if (!empty[0] && !empty[1]) gnt = rr_q;
      else if (!empty[0])         gnt = 1'b0;
      else                        gnt = 1'b1;
      pop[gnt] = !empty[gnt];
    end
    any_pop = |pop;
    head    = mem_q[gnt][rd_q[gnt][AW-1:0]];
  end

  // Next-state for pointers, stall hints, overflow, rr pointer and outputs.
  always_comb begin
    logic [PW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 2; i++) begin
      // A full FIFO still accepts a push when its head leaves at the same edge.
      push[i] = in_valid[i] && !flush_i && (!full[i] || pop[i]);
      if (flush_i) begin
        wr_d[i] = '0;
        rd_d[i] = '0;
      end else begin
        wr_d[i] = wr_q[i] + PW'(push[i]);
        rd_d[i] = rd_q[i] + PW'(pop[i]);
      end
      cnt        = wr_d[i] - rd_d[i];
      stall_d[i] = (DEPTH_W - cnt) <= SKID_W;
    end

    // A valid input that was neither flushed nor pushed hit a full FIFO.
    overflow_d = overflow_q | (|(in_valid & ~push & {2{!flush_i}}));
    rr_d       = any_pop ? ~gnt : rr_q;

    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    cmp_rob_d   = cmp_rob_q;
    wb_valid_d  = 1'b0;
    cmp_valid_d = 1'b0;
    if (any_pop) begin
      wb_data_d   = head.result;
      wb_dest_d   = head.dest;
      cmp_rob_d   = head.rob;
      wb_valid_d  = head.wb;
      cmp_valid_d = 1'b1;
    end
  end

  // Control state and output registers.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (core_reset_i) begin
      for (int i = 0; i < 2; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
      end
      stall_q     <= '0;
      rr_q        <= 1'b0;
      overflow_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      cmp_rob_q   <= '0;
      wb_valid_q  <= 1'b0;
      cmp_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_q[i] <= wr_d[i];
        rd_q[i] <= rd_d[i];
      end
      stall_q     <= stall_d;
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      cmp_rob_q   <= cmp_rob_d;
      wb_valid_q  <= wb_valid_d;
      cmp_valid_q <= cmp_valid_d;
    end
  end

  // FIFO storage writes.
  always_ff @(posedge core_clock_i) begin
    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are live, so stale contents are never observed.
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_q[i][AW-1:0]] <= in_entry[i];
    end
  end

  assign a_stall_o   = stall_q[0];
  assign b_stall_o   = stall_q[1];
  assign wb_data_o   = wb_data_q;
  assign wb_dest_o   = wb_dest_q;
  assign wb_valid_o  = wb_valid_q;
  assign cmp_rob_o   = cmp_rob_q;
  assign cmp_valid_o = cmp_valid_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ivalu_wb_arbiter.sv
// Bench for ivalu_wb_arbiter: a queue-based reference model of the two
// result FIFOs and the round-robin writeback port, a per-cycle compare of
// every output against it, and directed scenarios with literal expectations.
module tb_ivalu_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int SKID  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] a_res = '0, b_res = '0;
  logic [4:0]  a_rob = '0, b_rob = '0;
  logic [5:0]  a_dest = '0, b_dest = '0;
  logic        a_wb = 1'b0, b_wb = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;

  logic        a_stall_o, b_stall_o;
  logic [31:0] wb_data_o;
  logic [5:0]  wb_dest_o;
  logic        wb_valid_o;
  logic [4:0]  cmp_rob_o;
  logic        cmp_valid_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  ivalu_wb_arbiter #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .core_clock_i (clk),
    .core_reset_i (rst),
    .flush_i      (flush),
    .a_result_i   (a_res),
    .a_rob_i      (a_rob),
    .a_dest_i     (a_dest),
    .a_wb_valid_i (a_wb),
    .a_valid_i    (a_valid),
    .a_stall_o    (a_stall_o),
    .b_result_i   (b_res),
    .b_rob_i      (b_rob),
    .b_dest_i     (b_dest),
    .b_wb_valid_i (b_wb),
    .b_valid_i    (b_valid),
    .b_stall_o    (b_stall_o),
    .wb_data_o    (wb_data_o),
    .wb_dest_o    (wb_dest_o),
    .wb_valid_o   (wb_valid_o),
    .cmp_rob_o    (cmp_rob_o),
    .cmp_valid_o  (cmp_valid_o),
    .overflow_o   (overflow_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source, a tie-break preference and the
  // expected values of every output after each edge.
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rob;
    logic [5:0]  dest;
    logic        wb;
  } op_t;

  op_t         qa[$];
  op_t         qb[$];
  logic        pref_b = 1'b0;
  logic [31:0] e_data = '0;
  logic [5:0]  e_dest = '0;
  logic [4:0]  e_rob = '0;
  logic        e_wbv = 1'b0, e_cmp = 1'b0, e_ovf = 1'b0, e_sa = 1'b0, e_sb = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    op_t h;
    logic ga, gb;
    if (rst) begin
      qa.delete(); qb.delete();
      pref_b = 1'b0;
      e_data = '0; e_dest = '0; e_rob = '0;
      e_wbv = 1'b0; e_cmp = 1'b0; e_ovf = 1'b0; e_sa = 1'b0; e_sb = 1'b0;
    end else if (flush) begin
      qa.delete(); qb.delete();
      e_wbv = 1'b0; e_cmp = 1'b0; e_sa = 1'b0; e_sb = 1'b0;
    end else begin
      ga = (qa.size() > 0) && (qb.size() == 0 || !pref_b);
      gb = (qb.size() > 0) && !ga;
      if (ga) begin h = qa.pop_front(); pref_b = 1'b1; end
      else if (gb) begin h = qb.pop_front(); pref_b = 1'b0; end
      if (ga || gb) begin
        e_cmp = 1'b1; e_wbv = h.wb; e_data = h.res; e_dest = h.dest; e_rob = h.rob;
      end else begin
        e_cmp = 1'b0; e_wbv = 1'b0;
      end
      if (a_valid) begin
        if (qa.size() < DEPTH) qa.push_back('{a_res, a_rob, a_dest, a_wb});
        else e_ovf = 1'b1;
      end
      if (b_valid) begin
        if (qb.size() < DEPTH) qb.push_back('{b_res, b_rob, b_dest, b_wb});
        else e_ovf = 1'b1;
      end
      e_sa = (DEPTH - qa.size()) <= SKID;
      e_sb = (DEPTH - qb.size()) <= SKID;
    end
  end

  // Per-cycle compare of every output against the model, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    check("cmp_valid", cmp_valid_o, e_cmp);
    check("wb_valid",  wb_valid_o,  e_wbv);
    check("wb_data",   wb_data_o,   e_data);
    check("wb_dest",   wb_dest_o,   e_dest);
    check("cmp_rob",   cmp_rob_o,   e_rob);
    check("overflow",  overflow_o,  e_ovf);
    check("a_stall",   a_stall_o,   e_sa);
    check("b_stall",   b_stall_o,   e_sb);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic put_a(input logic [31:0] r, input logic [4:0] t, input logic [5:0] d, input logic w);
    a_valid = 1'b1; a_res = r; a_rob = t; a_dest = d; a_wb = w;
  endtask

  task automatic put_b(input logic [31:0] r, input logic [4:0] t, input logic [5:0] d, input logic w);
    b_valid = 1'b1; b_res = r; b_rob = t; b_dest = d; b_wb = w;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int na, nb, cyc, ncmp;
    logic stall_seen;

    // Reset state.
    idle();
    step();
    step();
    check("rst_cmp_valid", cmp_valid_o, 32'd0);
    check("rst_wb_valid",  wb_valid_o,  32'd0);
    check("rst_stall",     {a_stall_o, b_stall_o}, 32'd0);
    check("rst_overflow",  overflow_o,  32'd0);
    rst = 1'b0;

    // Single A op: visible exactly one edge after it is sampled.
    put_a(32'hDEADBEEF, 5'd3, 6'd7, 1'b1);
    step();
    idle();
    check("t1_no_bypass", cmp_valid_o, 32'd0);
    step();
    check("t1_wb_valid", wb_valid_o, 32'd1);
    check("t1_wb_data",  wb_data_o,  32'hDEADBEEF);
    check("t1_wb_dest",  wb_dest_o,  32'd7);
    check("t1_cmp_rob",  cmp_rob_o,  32'd3);
    step();
    check("t1_strobe_single", cmp_valid_o, 32'd0);
    check("t1_data_held", wb_data_o, 32'hDEADBEEF);

    // Completion without regfile write.
    put_a(32'h00001234, 5'd9, 6'd0, 1'b0);
    step();
    idle();
    step();
    check("t3_cmp_valid", cmp_valid_o, 32'd1);
    check("t3_wb_valid",  wb_valid_o,  32'd0);
    check("t3_cmp_rob",   cmp_rob_o,   32'd9);

    // Both sources busy, issue honouring the stall hints; 8 ops each.
    na = 0; nb = 0; cyc = 0; ncmp = 0; stall_seen = 1'b0;
    while ((na < 8 || nb < 8) && cyc < 100) begin
      idle();
      if (na < 8 && !a_stall_o) begin
        put_a(32'hA0000000 + 32'(na), 5'(na), 6'(na + 8), 1'b1);
        na++;
      end
      if (nb < 8 && !b_stall_o) begin
        put_b(32'hB0000000 + 32'(nb), 5'(nb + 16), 6'(nb + 32), 1'b1);
        nb++;
      end
      step();
      cyc++;
      if (cmp_valid_o) ncmp++;
      if (a_stall_o || b_stall_o) stall_seen = 1'b1;
    end
    idle();
    repeat (12) begin
      step();
      if (cmp_valid_o) ncmp++;
    end
    check("t2_issued_a",     na, 32'd8);
    check("t2_issued_b",     nb, 32'd8);
    check("t2_completions",  ncmp, 32'd16);
    check("t2_stall_seen",   stall_seen, 32'd1);
    check("t2_stall_clear",  {a_stall_o, b_stall_o}, 32'd0);
    check("t2_no_overflow",  overflow_o, 32'd0);

    // Fill A while B competes: push into full A with pop accepted (edge 7),
    // then push into full A without pop overflows (edge 8).
    do_reset();
    for (int k = 0; k < 9; k++) begin
      put_a(32'hC0000000 + 32'(k), 5'(k), 6'(k), 1'b1);
      if (k == 0 || k == 1 || k == 3 || k == 5) put_b(32'hB5000000 + 32'(k), 5'(k + 20), 6'(k + 40), 1'b1);
      else b_valid = 1'b0;
      step();
      if (k == 7) check("t4_full_pop_ok", overflow_o, 32'd0);
      if (k == 8) check("t4_overflow", overflow_o, 32'd1);
    end
    idle();
    repeat (10) step();
    check("t4_overflow_sticky", overflow_o, 32'd1);

    // Flush with three entries queued and an A op arriving the same cycle.
    put_a(32'h11110000, 5'd1, 6'd1, 1'b1);
    put_b(32'h22220000, 5'd2, 6'd2, 1'b1);
    step();
    put_a(32'h11110001, 5'd3, 6'd3, 1'b1);
    put_b(32'h22220001, 5'd4, 6'd4, 1'b1);
    step();
    b_valid = 1'b0;
    put_a(32'h11110002, 5'd5, 6'd5, 1'b1);
    flush = 1'b1;
    step();
    idle();
    check("t5_no_cmp",   cmp_valid_o, 32'd0);
    check("t5_stall",    {a_stall_o, b_stall_o}, 32'd0);
    check("t5_ovf_kept", overflow_o, 32'd1);
    repeat (3) begin
      step();
      check("t5_quiet", cmp_valid_o, 32'd0);
    end

    // Reset asserted between edges mid-stream.
    do_reset();
    put_a(32'h33330000, 5'd6, 6'd6, 1'b1);
    put_b(32'h44440000, 5'd7, 6'd7, 1'b1);
    step();
    put_a(32'h33330001, 5'd8, 6'd8, 1'b1);
    step();
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_cmp",  cmp_valid_o, 32'd0);
    check("t6_async_wb",   wb_valid_o,  32'd0);
    check("t6_async_data", wb_data_o,   32'd0);
    idle();
    step();
    check("t6_held_cmp", cmp_valid_o, 32'd0);
    rst = 1'b0;
    put_a(32'h55AA55AA, 5'd10, 6'd11, 1'b1);
    step();
    idle();
    check("t6_no_stale", cmp_valid_o, 32'd0);
    step();
    check("t6_cmp_valid", cmp_valid_o, 32'd1);
    check("t6_wb_data",   wb_data_o,   32'h55AA55AA);
    check("t6_wb_dest",   wb_dest_o,   32'd11);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
